// File: rtl/array_ctrl_pkg.sv
// Shared constants and state encoding for the SRAM requester controller.
package array_ctrl_pkg;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 74;
  localparam int LANES  = 2;
  localparam int LANE_W = DATA_W / LANES;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/array_resp_fifo.sv
// Two-entry in-order response buffer; simultaneous push and pop are both honoured.
module array_resp_fifo
  import array_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        count,
  output logic [DATA_W-1:0] head
);
  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        cnt;
  logic              push_ok;
  logic              pop_ok;

  assign pop_ok  = pop && (cnt != 2'd0);
  assign push_ok = push && ((cnt != 2'd2) || pop_ok);
  assign count   = cnt;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/array_req_ctrl.sv
// Arbitrates write/read request channels onto a single-port SRAM, zero-fills it
// after reset and buffers read responses across the macro's 1-cycle latency.
module array_req_ctrl
  import array_ctrl_pkg::*;
#(
  parameter int INIT_ON_RESET = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [LANES-1:0]  w_mask,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              init_done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [LANES-1:0]  sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);
  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] init_cnt;
  logic              rr_read;    // 1: read wins the next contended cycle
  logic              rd_vld_p1;  // read issued last cycle, rdata valid now
  logic [1:0]        fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic [1:0]        occ;
  logic              run;
  logic              pop;
  logic              rd_ok;
  logic              grant_w;
  logic              grant_r;

  assign run        = (state == RUN) && !reset;
  assign resp_valid = (fifo_count != 2'd0) && !reset;
  assign resp_data  = fifo_head;
  assign pop        = resp_valid && resp_ready;
  // Credit: buffered plus in-flight responses, less the one leaving this cycle.
  assign occ        = fifo_count + {1'b0, rd_vld_p1} - {1'b0, pop};
  assign rd_ok      = run && r_valid && (occ < 2'd2);
  assign grant_w    = run && w_valid && (!rd_ok || !rr_read);
  assign grant_r    = rd_ok && (!w_valid || rr_read);
  assign w_ready    = grant_w;
  assign r_ready    = grant_r;
  assign init_done  = run;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= (INIT_ON_RESET != 0) ? INIT : RUN;
      init_cnt  <= '0;
      rr_read   <= 1'b0;
      rd_vld_p1 <= 1'b0;
    end else begin
      state     <= state_nxt;
      rd_vld_p1 <= grant_r;
      if (state == INIT) init_cnt <= init_cnt + 1'b1;
      if (w_valid && rd_ok) rr_read <= ~rr_read;
    end
  end

  always_comb begin
    state_nxt  = state;
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = w_addr;
    sram_wmask = w_mask;
    sram_wdata = w_data;
    case (state)
      INIT: begin
        if (!reset) begin
          sram_en    = 1'b1;
          sram_wmode = 1'b1;
          sram_addr  = init_cnt;
          sram_wmask = '1;
          sram_wdata = '0;
        end
        if (init_cnt == ADDR_W'(DEPTH - 1)) state_nxt = RUN;
      end
      RUN: begin
        if (grant_w) begin
          sram_en    = 1'b1;
          sram_wmode = 1'b1;
        end else if (grant_r) begin
          sram_en    = 1'b1;
          sram_addr  = r_addr;
        end
      end
      default: state_nxt = state;
    endcase
  end

  // Response stage: rdata captured the cycle after the read was issued.
  array_resp_fifo u_resp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rd_vld_p1),
    .push_data (sram_rdata),
    .pop       (pop),
    .count     (fifo_count),
    .head      (fifo_head)
  );
endmodule
